boot_run_ctrl: RTL
==================

# boot_run_ctrl

Program-load and run sequencer for the single-cycle RV32I core. It accepts a byte stream from an external loader, packs it little-endian into 32-bit words, and writes them into instruction memory. It holds the core in reset while loading, then releases it and gates it with a clock enable. It stops the core when the halt instruction is fetched and reports cycles executed. It sits between the board or testbench loader and the `Top` core wrapper, driving the core's reset and enable and the instruction-memory write port.

## Interface
Parameters:
- `WIDTH`, 32: instruction and data word width.
- `ADDR_WIDTH`, 10: instruction-memory byte-address width. Capacity is `2**(ADDR_WIDTH-2)` words.
- `HALT_INSTR`, 32'h0000006F: encoding treated as halt (`jal x0, 0`).

Ports:
- `clk` in 1: clock. One clock domain; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: single-cycle pulse; begins a load from IDLE or HALT.
- `abort` in 1: return to IDLE from any state.
- `ld_valid` in 1: loader byte valid.
- `ld_data` in 8: loader byte.
- `ld_last` in 1: marks the final byte of the program. Qualified by `ld_valid`.
- `ld_ready` out 1: controller accepts a byte this cycle.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_waddr` out `ADDR_WIDTH`: write byte address, word aligned.
- `imem_wdata` out `WIDTH`: write data.
- `cpu_rst` out 1: reset to the core, active-high.
- `cpu_en` out 1: clock enable to the core (PC, register file and data-memory writes).
- `instr` in `WIDTH`: instruction currently fetched by the core.
- `halted` out 1: core stopped on the halt instruction.
- `cycle_count` out `WIDTH`: enabled core cycles in the current or last run.

## Operation
States: IDLE, LOAD, FLUSH, RUN, HALT. All outputs are registered.

Reset values: state IDLE, `ld_ready`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `cpu_rst`=1, `cpu_en`=0, `halted`=0, `cycle_count`=0.

- **IDLE:** `cpu_rst`=1. On `start` go to LOAD; clear the byte lane, word index, `cycle_count` and `halted`.
- **LOAD:** `ld_ready`=1, `cpu_rst`=1.
  - A byte is accepted on an edge where `ld_valid && ld_ready`. Byte lane k (0..3) fills bits [8k+7:8k] of the assembly register.
  - When lane 3 is accepted, the next cycle has `imem_we`=1, `imem_wdata`=assembled word and `imem_waddr`=word index×4. The word index then increments. Loading continues without a bubble.
- **ld_last:** when the accepted byte has `ld_last`=1, the partial word is written with unfilled lanes zero. The write happens even if lane 0 was the last lane filled. State moves to FLUSH; `ld_ready`=0 from the next cycle.
- **Full memory:** if the word just written has index `2**(ADDR_WIDTH-2)-1`, this is treated as `ld_last`: go to FLUSH and drop `ld_ready`. Further bytes are never accepted.
- **FLUSH:** one cycle. `imem_we` is deasserted and `cpu_rst` stays 1. Then go to RUN.
- **RUN:** `cpu_rst`=0, `cpu_en`=1.
  - `cycle_count` increments each RUN cycle and saturates at all-ones.
  - If `instr == HALT_INSTR` while `cpu_en`=1, go to HALT next edge. That cycle is counted.
- **HALT:** `cpu_en`=0, `cpu_rst`=0 (architectural state is preserved for inspection), `halted`=1, `cycle_count` frozen. On `start` go to LOAD (as from IDLE).
- **abort:** from any state, go to IDLE next edge with the reset-value outputs. The partial word is discarded and no write is issued. `abort` takes priority over `start`, `ld_valid` and halt detection.
- **Ignored inputs:** `start` is ignored in LOAD, FLUSH and RUN. `ld_valid` outside LOAD is ignored.

## Timing
- `ld_ready` asserts the cycle after `start` is sampled.
- Write latency: exactly one cycle from acceptance of the completing byte to `imem_we`. `imem_we` is a one-cycle pulse per word.
- Core release: `cpu_rst` falls and `cpu_en` rises two cycles after the final write pulse (the FLUSH cycle is between them).
- Halt: `cpu_en` falls on the edge after `HALT_INSTR` is presented. The core executes no instruction after the halt fetch.
- `rst` mid-operation: same behaviour as reset; any pending write is dropped.

## Test plan
- **Load 8 bytes and run:** `start`, bytes 13 05 A0 00 6F 00 00 00, `ld_last` on the 8th byte.
  - Writes: `imem_we` at addr 0 with 0x00A00513, then addr 4 with 0x0000006F.
  - FLUSH, then RUN.
  - `halted`=1 with `cycle_count`=2.
- **Partial word:** 5 bytes 11 22 33 44 55 with `ld_last` on 55.
  - Second write is addr 4, data 0x00000055.
  - `ld_ready`=0 the cycle after the last byte is accepted.
- **Backpressure and gaps:** `ld_valid` toggles randomly. Bytes are accepted only when valid and ready. Word contents and addresses match the sequential reference. No write occurs without a full word or `ld_last`.
- **Full memory (ADDR_WIDTH=4):** stream 20 bytes.
  - Exactly 4 writes, at addrs 0, 4, 8, 12.
  - `ld_ready` drops after byte 16. Bytes 17–20 are not accepted.
  - RUN follows.
- **Abort:** assert `abort` mid-word in LOAD. Next cycle: IDLE, no `imem_we`, `cpu_rst`=1. Repeat during RUN: `cpu_en`=0 and `cpu_rst`=1 next cycle. `start` and `abort` asserted together leave the block in IDLE.
- **Saturation and restart:** force `cycle_count` near all-ones in RUN; it saturates at 0xFFFFFFFF. A `start` from HALT clears `halted` and `cycle_count` and re-enters LOAD.

Source files
------------

// File: rtl/boot_run_ctrl_if.sv
// Loader byte stream and instruction-memory write port of boot_run_ctrl.
// The master side is the loader / memory owner; the slave side is the controller.
interface boot_run_ctrl_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  ld_valid;
    logic [7:0]            ld_data;
    logic                  ld_last;
    logic                  ld_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_waddr;
    logic [WIDTH-1:0]      imem_wdata;

    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/boot_run_ctrl.sv
// Program-load and run sequencer: packs loader bytes into instruction memory,
// then releases the core, counts its cycles and stops it on the halt fetch.
module boot_run_ctrl #(
    parameter int               WIDTH      = 32,
    parameter int               ADDR_WIDTH = 10,
    parameter logic [WIDTH-1:0] HALT_INSTR = 32'h0000006F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    boot_run_ctrl_if.slave   lif,
    output logic             cpu_rst,
    output logic             cpu_en,
    input  logic [WIDTH-1:0] instr,
    output logic             halted,
    output logic [WIDTH-1:0] cycle_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [ADDR_WIDTH-3:0] LAST_IDX = '1;

    state_t                state;
    logic [1:0]            lane;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [WIDTH-1:0]      asm_word;

    logic [WIDTH-1:0]      next_word;
    logic                  word_done;
    logic                  load_done;

    always_comb begin
        next_word = asm_word | (WIDTH'(lif.ld_data) << {lane, 3'b000});
        word_done = (lane == 2'd3) || lif.ld_last;
        load_done = lif.ld_last || ((lane == 2'd3) && (word_idx == LAST_IDX));
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state          <= S_IDLE;
            lif.ld_ready   <= 1'b0;
            lif.imem_we    <= 1'b0;
            lif.imem_waddr <= '0;
            lif.imem_wdata <= '0;
            cpu_rst        <= 1'b1;
            cpu_en         <= 1'b0;
            halted         <= 1'b0;
            cycle_count    <= '0;
            lane           <= '0;
            word_idx       <= '0;
            asm_word       <= '0;
        end else begin
            lif.imem_we <= 1'b0;
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state        <= S_LOAD;
                        lif.ld_ready <= 1'b1;
                        cpu_rst      <= 1'b1;
                        cpu_en       <= 1'b0;
                        halted       <= 1'b0;
                        cycle_count  <= '0;
                        lane         <= '0;
                        word_idx     <= '0;
                        asm_word     <= '0;
                    end
                end
                S_LOAD: begin
                    // ld_ready low inside LOAD marks the final write cycle;
                    // FLUSH follows so the core sees one idle cycle after it.
                    if (!lif.ld_ready) begin
                        state <= S_FLUSH;
                    end else if (lif.ld_valid) begin
                        if (word_done) begin
                            lif.imem_we    <= 1'b1;
                            lif.imem_wdata <= next_word;
                            lif.imem_waddr <= {word_idx, 2'b00};
                            word_idx       <= word_idx + 1'b1;
                            asm_word       <= '0;
                            lane           <= '0;
                        end else begin
                            asm_word <= next_word;
                            lane     <= lane + 1'b1;
                        end
                        if (load_done) begin
                            lif.ld_ready <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    state   <= S_RUN;
                    cpu_rst <= 1'b0;
                    cpu_en  <= 1'b1;
                end
                S_RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    if (cpu_en && (instr == HALT_INSTR)) begin
                        state  <= S_HALT;
                        cpu_en <= 1'b0;
                        halted <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
